// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg
// Shared types and helpers for the icache replacement controller.
//   flush_state_t : flush sequencer states (IDLE, FLUSH, DONE)
//   plru_width()  : number of tree-PLRU bits per set for a given way count
package sargantana_icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } flush_state_t;

    // A binary tree over N leaves has N-1 internal nodes.
    function automatic int plru_width(input int n_way);
        return n_way - 1;
    endfunction

endpackage

// File: rtl/sargantana_icache_lfsr.sv
// sargantana_icache_lfsr
// 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1), seeded to 8'h01.
// Ports:
//   clk_i, rstn_i    clock, async active-low reset
//   en_i             advance one step
//   out_o [OUT_W]    low OUT_W bits of the current state
module sargantana_icache_lfsr #(
    parameter int OUT_W = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] out_o
);

    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d = en_i ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                         : lfsr_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/sargantana_icache_plru_tree.sv
// sargantana_icache_plru_tree
// Combinational tree-PLRU for one set. Nodes are heap-ordered: node n has
// children 2n+1 (left, lower ways) and 2n+2. A node bit of 0 points left.
// Ports:
//   plru_i       [N_WAY-1]   tree bits of the set
//   access_way_i [WAY_W]     way being touched
//   victim_o     [WAY_W]     way reached by following the tree bits
//   upd_mask_o   [N_WAY-1]   nodes on access_way_i's path
//   upd_val_o    [N_WAY-1]   new values for those nodes (point away)
module sargantana_icache_plru_tree #(
    parameter int N_WAY = 4
) (
    input  logic [N_WAY-2:0]         plru_i,
    input  logic [$clog2(N_WAY)-1:0] access_way_i,
    output logic [$clog2(N_WAY)-1:0] victim_o,
    output logic [N_WAY-2:0]         upd_mask_o,
    output logic [N_WAY-2:0]         upd_val_o
);

    localparam int WW = $clog2(N_WAY);
    localparam int PW = N_WAY - 1;

    always_comb begin
        int   node;
        logic bit_v;
        node     = 0;
        victim_o = '0;
        for (int l = 0; l < WW; l++) begin
            bit_v = 1'b0;
            for (int n = 0; n < PW; n++) begin
                if (n == node) bit_v = plru_i[n];
            end
            victim_o[WW-1-l] = bit_v;
            node = 2 * node + 1 + int'(bit_v);
        end
    end

    always_comb begin
        int   node;
        logic a;
        node       = 0;
        upd_mask_o = '0;
        upd_val_o  = '0;
        for (int l = 0; l < WW; l++) begin
            a = access_way_i[WW-1-l];
            for (int n = 0; n < PW; n++) begin
                if (n == node) begin
                    upd_mask_o[n] = 1'b1;
                    upd_val_o[n]  = ~a;
                end
            end
            node = 2 * node + 1 + int'(a);
        end
    end

endmodule

// File: rtl/sargantana_icache_tzc.sv
// sargantana_icache_tzc
// Trailing-zero counter: index of the lowest set bit of in_i.
// Ports:
//   in_i    [WIDTH]          input vector
//   cnt_o   [clog2(WIDTH)]   index of lowest set bit (0 when empty)
//   empty_o                  in_i is all zeros
module sargantana_icache_tzc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] cnt_o,
    output logic                     empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = ~(|in_i);
        // Scan downwards so the lowest set bit wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = ($clog2(WIDTH))'(i);
            end
        end
    end

endmodule

// File: rtl/sargantana_icache_repl_ctrl.sv
// sargantana_icache_repl_ctrl
// Icache way-replacement and valid-bit controller: invalid-first victim
// selection with PLRU (ICACHE_PLRU_EN defined) or LFSR fallback, single-way
// invalidation and a self-sequenced full flush walking every set.
// Build option: ICACHE_PLRU_EN selects the per-set tree PLRU policy.
// Ports:
//   clk_i, rstn_i                           clock, async active-low reset
//   flush_req_i / flush_busy_o / flush_done_o   flush request and status
//   inval_i, inval_idx_i, inval_way_i       single-way invalidation
//   cache_rd_ena_i, cache_wr_ena_i          lookup / refill of latched victim
//   hit_i, hit_way_i                        lookup result (PLRU touch)
//   cmp_en_i, cline_index_i, way_valid_bits_i   victim selection inputs
//   way_to_replace_o                        registered victim
//   we_valid_o, valid_bit_o, addr_valid_o   valid-bit RAM write port
//   tag_req_valid_o, data_req_valid_o       per-way RAM enables
module sargantana_icache_repl_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int  ICACHE_N_WAY     = 4,
    parameter int  ICACHE_IDX_WIDTH = 6,
    localparam int WAY_W            = $clog2(ICACHE_N_WAY)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        flush_req_i,
    output logic                        flush_busy_o,
    output logic                        flush_done_o,
    input  logic                        inval_i,
    input  logic [ICACHE_IDX_WIDTH-1:0] inval_idx_i,
    input  logic [WAY_W-1:0]            inval_way_i,
    input  logic                        cache_rd_ena_i,
    input  logic                        cache_wr_ena_i,
    input  logic                        hit_i,
    input  logic [WAY_W-1:0]            hit_way_i,
    input  logic                        cmp_en_i,
    input  logic [ICACHE_IDX_WIDTH-1:0] cline_index_i,
    input  logic [ICACHE_N_WAY-1:0]     way_valid_bits_i,
    output logic [WAY_W-1:0]            way_to_replace_o,
    output logic                        we_valid_o,
    output logic                        valid_bit_o,
    output logic [ICACHE_IDX_WIDTH-1:0] addr_valid_o,
    output logic [ICACHE_N_WAY-1:0]     tag_req_valid_o,
    output logic [ICACHE_N_WAY-1:0]     data_req_valid_o
);

    localparam int N_SETS = 2 ** ICACHE_IDX_WIDTH;
    localparam int PW     = plru_width(ICACHE_N_WAY);

    flush_state_t                state_q, state_d;
    logic [ICACHE_IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic [WAY_W-1:0]            victim_q, victim_d;
    logic                        idle, do_inval, do_wr, do_rd;
    logic [WAY_W-1:0]            first_invalid, policy_way;
    logic                        all_valid;

    // Request decode with inval > wr > rd priority; nothing acts outside IDLE.
    assign idle     = (state_q == IDLE);
    assign do_inval = idle & inval_i;
    assign do_wr    = idle & ~inval_i & cache_wr_ena_i;
    assign do_rd    = idle & ~inval_i & ~cache_wr_ena_i & cache_rd_ena_i;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        flush_busy_o     = 1'b0;
        flush_done_o     = 1'b0;
        we_valid_o       = 1'b0;
        valid_bit_o      = 1'b0;
        addr_valid_o     = cline_index_i;
        tag_req_valid_o  = '0;
        data_req_valid_o = '0;
        case (state_q)
            IDLE: begin
                if (flush_req_i) state_d = FLUSH;
                if (do_inval) begin
                    addr_valid_o    = inval_idx_i;
                    we_valid_o      = 1'b1;
                    tag_req_valid_o = ICACHE_N_WAY'(1) << inval_way_i;
                end else if (do_wr) begin
                    we_valid_o       = 1'b1;
                    valid_bit_o      = 1'b1;
                    tag_req_valid_o  = ICACHE_N_WAY'(1) << victim_q;
                    data_req_valid_o = ICACHE_N_WAY'(1) << victim_q;
                end else if (do_rd) begin
                    tag_req_valid_o  = '1;
                    data_req_valid_o = '1;
                end
            end
            FLUSH: begin
                flush_busy_o    = 1'b1;
                addr_valid_o    = cnt_q;
                we_valid_o      = 1'b1;
                tag_req_valid_o = '1;
                // Natural wrap returns the counter to 0 on the last set.
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == ICACHE_IDX_WIDTH'(N_SETS - 1)) state_d = DONE;
            end
            DONE: begin
                flush_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
        end
    end

    sargantana_icache_tzc #(.WIDTH(ICACHE_N_WAY)) u_tzc (
        .in_i    (~way_valid_bits_i),
        .cnt_o   (first_invalid),
        .empty_o (all_valid)
    );

    assign victim_d         = (idle & cmp_en_i) ? (all_valid ? policy_way : first_invalid)
                                                : victim_q;
    assign way_to_replace_o = victim_q;

`ifdef ICACHE_PLRU_EN
    logic [PW-1:0]               plru_q [N_SETS];
    logic [PW-1:0]               plru_cur, upd_mask, upd_val, plru_set_d;
    logic [WAY_W-1:0]            access_way;
    logic                        plru_we;
    logic [ICACHE_IDX_WIDTH-1:0] plru_addr;

    assign plru_cur   = plru_q[cline_index_i];
    assign access_way = do_wr ? victim_q : hit_way_i;

    sargantana_icache_plru_tree #(.N_WAY(ICACHE_N_WAY)) u_plru_tree (
        .plru_i       (plru_cur),
        .access_way_i (access_way),
        .victim_o     (policy_way),
        .upd_mask_o   (upd_mask),
        .upd_val_o    (upd_val)
    );

    always_comb begin
        plru_we    = 1'b0;
        plru_addr  = cline_index_i;
        plru_set_d = plru_cur;
        if (state_q == FLUSH) begin
            plru_we    = 1'b1;
            plru_addr  = cnt_q;
            plru_set_d = '0;
        end else if (do_wr || (do_rd && hit_i)) begin
            plru_we    = 1'b1;
            plru_set_d = (plru_cur & ~upd_mask) | (upd_val & upd_mask);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < N_SETS; s++) plru_q[s] <= '0;
        end else if (plru_we) begin
            plru_q[plru_addr] <= plru_set_d;
        end
    end
`else
    logic unused_hit;
    assign unused_hit = ^{hit_i, hit_way_i};

    sargantana_icache_lfsr #(.OUT_W(WAY_W)) u_lfsr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (do_wr & (&way_valid_bits_i)),
        .out_o  (policy_way)
    );
`endif

endmodule

// File: tb/tb_sargantana_icache_repl_ctrl.sv
module tb_sargantana_icache_repl_ctrl;

    localparam int NW = 4;
    localparam int IW = 6;
    localparam int WW = 2;
    localparam int NS = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          flush_req, inval, rd, wr, hit, cmp;
    logic [IW-1:0] inval_idx, cline;
    logic [WW-1:0] inval_way, hit_way;
    logic [NW-1:0] valid;
    logic          busy, done, we, vb;
    logic [WW-1:0] way;
    logic [IW-1:0] addr;
    logic [NW-1:0] tag_en, data_en;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0 = idle, 1..NS = flushing set phase-1, NS+1 = done.
    int            m_phase;
    logic [WW-1:0] m_victim;
    logic [7:0]    m_lfsr;
    bit [NW-2:0]   m_tree [NS];

    always #5 clk = ~clk;

    sargantana_icache_repl_ctrl dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .flush_req_i      (flush_req),
        .flush_busy_o     (busy),
        .flush_done_o     (done),
        .inval_i          (inval),
        .inval_idx_i      (inval_idx),
        .inval_way_i      (inval_way),
        .cache_rd_ena_i   (rd),
        .cache_wr_ena_i   (wr),
        .hit_i            (hit),
        .hit_way_i        (hit_way),
        .cmp_en_i         (cmp),
        .cline_index_i    (cline),
        .way_valid_bits_i (valid),
        .way_to_replace_o (way),
        .we_valid_o       (we),
        .valid_bit_o      (vb),
        .addr_valid_o     (addr),
        .tag_req_valid_o  (tag_en),
        .data_req_valid_o (data_en)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] lowest_invalid(input logic [NW-1:0] v);
        logic [WW-1:0] r = '0;
        for (int i = NW - 1; i >= 0; i--) if (!v[i]) r = WW'(i);
        return r;
    endfunction

    function automatic logic [WW-1:0] policy_victim(input logic [IW-1:0] idx);
`ifdef ICACHE_PLRU_EN
        int node = 0;
        int w = 0;
        for (int l = 0; l < WW; l++) begin
            int b = int'(m_tree[idx][node]);
            w    = 2 * w + b;
            node = 2 * node + 1 + b;
        end
        return WW'(w);
`else
        return m_lfsr[WW-1:0];
`endif
    endfunction

    task automatic touch(input logic [IW-1:0] idx, input logic [WW-1:0] w);
        int node = 0;
        for (int l = 0; l < WW; l++) begin
            int b = int'(w[WW-1-l]);
            m_tree[idx][node] = (b == 0);
            node = 2 * node + 1 + b;
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_victim = '0;
        m_lfsr   = 8'h01;
        for (int s = 0; s < NS; s++) m_tree[s] = '0;
    endtask

    task automatic check_outputs();
        logic          e_busy, e_done, e_we, e_vb;
        logic [IW-1:0] e_addr;
        logic [NW-1:0] e_tag, e_data;
        e_busy = (m_phase >= 1) && (m_phase <= NS);
        e_done = (m_phase == NS + 1);
        e_we = 1'b0; e_vb = 1'b0; e_addr = cline; e_tag = '0; e_data = '0;
        if (e_busy) begin
            e_addr = IW'(m_phase - 1); e_we = 1'b1; e_tag = '1;
        end else if (!e_done) begin
            if (inval) begin
                e_addr = inval_idx; e_we = 1'b1; e_tag = NW'(1) << inval_way;
            end else if (wr) begin
                e_we = 1'b1; e_vb = 1'b1;
                e_tag = NW'(1) << m_victim; e_data = NW'(1) << m_victim;
            end else if (rd) begin
                e_tag = '1; e_data = '1;
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("we_valid", 32'(we), 32'(e_we));
        chk("valid_bit", 32'(vb), 32'(e_vb));
        chk("addr_valid", 32'(addr), 32'(e_addr));
        chk("tag_req", 32'(tag_en), 32'(e_tag));
        chk("data_req", 32'(data_en), 32'(e_data));
        chk("victim", 32'(way), 32'(m_victim));
    endtask

    task automatic model_step();
        logic [WW-1:0] nv;
        if (m_phase == 0) begin
            nv = m_victim;
            if (cmp) nv = (&valid) ? policy_victim(cline) : lowest_invalid(valid);
            if (!inval) begin
                if (wr) begin
`ifdef ICACHE_PLRU_EN
                    touch(cline, m_victim);
`else
                    if (&valid) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
                end else if (rd && hit) begin
`ifdef ICACHE_PLRU_EN
                    touch(cline, hit_way);
`endif
                end
            end
            m_victim = nv;
            if (flush_req) m_phase = 1;
        end else if (m_phase <= NS) begin
            m_tree[m_phase-1] = '0;
            m_phase++;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        flush_req = 0; inval = 0; rd = 0; wr = 0; hit = 0; cmp = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_vb", 32'(vb), 0);
        chk("rst_tag", 32'(tag_en), 0);
        chk("rst_data", 32'(data_en), 0);
        chk("rst_victim", 32'(way), 0);
        chk("rst_addr", 32'(addr), 32'(cline));
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_busy_edge", 32'(busy), 0);
        rstn = 1'b1;
    endtask

    initial begin
        quiet();
        inval_idx = '0; inval_way = '0; hit_way = '0; cline = 6'd3; valid = '1;
        #3;
        do_reset();

        // Full flush with a lookup held active throughout.
        rd = 1; flush_req = 1;
        cycle();
        flush_req = 0; cmp = 1; valid = 4'b0111;
        for (int k = 0; k < NS; k++) begin
            chk("flush_addr", 32'(addr), 32'(k));
            chk("flush_busy", 32'(busy), 1);
            chk("flush_we", 32'(we), 1);
            chk("flush_tag", 32'(tag_en), 32'hF);
            cycle();
        end
        chk("flush_done_pulse", 32'(done), 1);
        chk("flush_busy_end", 32'(busy), 0);
        chk("flush_victim_held", 32'(way), 0);
        quiet();
        cycle();
        chk("flush_done_clear", 32'(done), 0);

        // Invalid-first selection.
        cline = 6'd9; valid = 4'b1011; cmp = 1;
        cycle();
        cmp = 0;
        chk("invalid_first", 32'(way), 2);

        // Inval beats a coincident refill write.
        inval = 1; inval_idx = 6'd7; inval_way = 2'd3; wr = 1;
        #1;
        chk("inval_addr", 32'(addr), 7);
        chk("inval_tag", 32'(tag_en), 32'h8);
        chk("inval_vb", 32'(vb), 0);
        chk("inval_data", 32'(data_en), 0);
        cycle();
        quiet();

        cline = 6'd5; valid = '1;
`ifdef ICACHE_PLRU_EN
        rd = 1; hit = 1;
        for (int w = 0; w < NW; w++) begin
            hit_way = WW'(w);
            cycle();
        end
        quiet(); cmp = 1;
        cycle();
        chk("plru_after_0123", 32'(way), 0);
        cmp = 0; rd = 1; hit = 1; hit_way = 2'd0;
        cycle();
        quiet(); cmp = 1;
        cycle();
        chk("plru_after_hit0", 32'(way), 2);
        cmp = 0;
`else
        cmp = 1;
        cycle();
        chk("lfsr_first", 32'(way), 1);
        cmp = 0; wr = 1;
        cycle();
        wr = 0; cmp = 1;
        cycle();
        chk("lfsr_second", 32'(way), 2);
        cmp = 0; rd = 1; hit = 1; hit_way = 2'd2;
        cycle();
        quiet(); cmp = 1;
        cycle();
        chk("lfsr_hit_ignored", 32'(way), 2);
        cmp = 0;
        for (int r = 0; r < 16; r++) begin
            wr = 1; cycle(); wr = 0;
            cmp = 1; cycle(); cmp = 0;
        end
`endif

        // Reset in the middle of a flush.
        flush_req = 1;
        cycle();
        flush_req = 0;
        for (int k = 0; k < 10; k++) cycle();
        do_reset();
        for (int k = 0; k < 3; k++) cycle();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            flush_req = ($urandom_range(0, 299) == 0);
            inval     = ($urandom_range(0, 7) == 0);
            wr        = ($urandom_range(0, 5) == 0);
            rd        = ($urandom_range(0, 1) == 0);
            hit       = ($urandom_range(0, 1) == 0);
            cmp       = ($urandom_range(0, 2) == 0);
            inval_idx = IW'($urandom);
            inval_way = WW'($urandom);
            hit_way   = WW'($urandom);
            cline     = IW'($urandom_range(0, 7));
            valid     = ($urandom_range(0, 1) == 0) ? '1 : NW'($urandom);
            cycle();
        end
        quiet();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_repl_ctrl.md
# sargantana_icache_repl_ctrl

Next-generation instruction-cache replacement and valid-bit controller. It replaces the fixed random/invalid-first way selection with a per-set tree pseudo-LRU policy, which is compiled in or out. It adds single-way invalidation at an arbitrary index and a self-sequenced full-cache flush state machine. It sits between the icache controller FSM and the tag/data RAM arrays, and drives the valid-bit write port and the RAM request enables.

## Interface
- ICACHE_N_WAY, 4, number of ways; power of two, ≥2
- ICACHE_IDX_WIDTH, 6, set index width; N_SETS = 2**ICACHE_IDX_WIDTH
- WAY_W, $clog2(ICACHE_N_WAY), derived; not overridable

Ports:
- clk_i  in  1  clock; single clock domain
- rstn_i  in  1  reset; asynchronous, active-low
- flush_req_i  in  1  request a full-cache flush; level or pulse
- flush_busy_o  out  1  flush walk in progress
- flush_done_o  out  1  one-cycle pulse when the walk completes
- inval_i  in  1  invalidate one way of one set
- inval_idx_i  in  ICACHE_IDX_WIDTH  set to invalidate
- inval_way_i  in  WAY_W  way to invalidate
- cache_rd_ena_i  in  1  core lookup
- cache_wr_ena_i  in  1  refill write of the latched victim
- hit_i  in  1  lookup hit, qualified by cache_rd_ena_i
- hit_way_i  in  WAY_W  hitting way
- cmp_en_i  in  1  tag-compare cycle; latches the victim
- cline_index_i  in  ICACHE_IDX_WIDTH  core set index
- way_valid_bits_i  in  ICACHE_N_WAY  valid bits of the set being compared
- way_to_replace_o  out  WAY_W  registered victim way
- we_valid_o  out  1  valid-bit RAM write enable
- valid_bit_o  out  1  value to write: 1 on refill, 0 on inval/flush
- addr_valid_o  out  ICACHE_IDX_WIDTH  valid/tag RAM address
- tag_req_valid_o  out  ICACHE_N_WAY  tag RAM per-way enable
- data_req_valid_o  out  ICACHE_N_WAY  data RAM per-way enable

## Operation
- **FSM states**
  - IDLE → FLUSH on flush_req_i.
  - FLUSH: flush counter steps 0..N_SETS-1, one set per cycle.
  - After set N_SETS-1: FLUSH → DONE.
  - DONE → IDLE unconditionally; flush_done_o is high in DONE.
- **FLUSH outputs, every cycle**
  - addr_valid_o = counter, we_valid_o=1, valid_bit_o=0, tag_req_valid_o='1, data_req_valid_o=0.
  - The PLRU bits of that set are cleared.
- **Priority:** FLUSH > inval > wr > rd.
  - During FLUSH/DONE: inval_i, rd, wr and cmp_en_i are ignored, and the PLRU and victim registers hold.
  - flush_req_i while busy has no effect.
- **Inval (IDLE)**
  - addr_valid_o=inval_idx_i, we_valid_o=1, valid_bit_o=0.
  - tag_req_valid_o = onehot(inval_way_i); data_req_valid_o=0.
  - PLRU is untouched.
  - If inval_i and cache_wr_ena_i coincide, the wr is dropped. This is legal but the caller must retry.
- **Wr (IDLE, no inval)**
  - addr_valid_o=cline_index_i, we_valid_o=1, valid_bit_o=1.
  - tag_req_valid_o = data_req_valid_o = onehot(way_to_replace_o).
  - The PLRU of cline_index_i is updated to point away from way_to_replace_o.
- **Rd (IDLE)**
  - addr_valid_o=cline_index_i; tag_req_valid_o = data_req_valid_o = '1.
  - If hit_i, the PLRU of cline_index_i is updated away from hit_way_i.
- **Idle default:** addr_valid_o=cline_index_i and all enables 0.
- **Victim selection, combinational on cmp_en_i**
  - If any bit of way_valid_bits_i is 0, the victim is the lowest-index invalid way.
  - Otherwise the victim comes from the policy: PLRU tree walk of cline_index_i, or LFSR.
  - way_to_replace_o is registered on cmp_en_i and holds otherwise.
- **PLRU state**
  - N_SETS × (ICACHE_N_WAY-1) flops.
  - Tree bit = 0 means the victim is on the left (lower ways).
  - On update, the bits on the accessed way's path are set to point to the opposite subtree.

## Timing
- Reset values:
  - FSM=IDLE, counter=0, PLRU=0, way_to_replace_o=0.
  - flush_busy_o=0, flush_done_o=0, we_valid_o=0, valid_bit_o=0, enables=0.
  - addr_valid_o=cline_index_i.
- All RAM-side outputs are combinational from the current state and inputs: zero-cycle latency.
- way_to_replace_o is valid the cycle after cmp_en_i.
- PLRU update is visible to a victim selection one cycle later.
- Same-cycle PLRU update and cmp_en_i on the same set: selection uses the pre-update state.
- Flush timing:
  - flush_req_i sampled at edge t.
  - FLUSH occupies cycles t+1 .. t+N_SETS.
  - flush_done_o and DONE occur at cycle t+N_SETS+1.
  - flush_busy_o is high for exactly N_SETS cycles.
- Counter wraps to 0 on leaving FLUSH.
- Reset asserted mid-flush aborts to IDLE immediately, with no done pulse.

## Configuration
- ICACHE_PLRU_EN defined: PLRU array and tree logic present; full-set victim = PLRU victim.
- ICACHE_PLRU_EN undefined:
  - No PLRU flops.
  - Full-set victim comes from sargantana_icache_lfsr, which advances on wr when all ways are valid.
  - hit_i/hit_way_i are unused.
  - Flush behaviour is unchanged.

## Structure
- sargantana_icache_pkg gains:
  - flush_state_t enum (IDLE, FLUSH, DONE)
  - a localparam helper for the PLRU width, ICACHE_N_WAY-1
- One natural sub-module: sargantana_icache_plru_tree, a combinational victim walk plus update-mask/value for one set, parametrised by ICACHE_N_WAY.
- Existing sargantana_icache_lfsr and sargantana_icache_tzc are reused unchanged.

## Test plan
- **Reset:** rstn_i low mid-sim → all outputs at reset values; flush_busy_o=0 on the next edge.
- **Flush with ICACHE_IDX_WIDTH=6:** flush_req_i pulse → addr_valid_o steps 0..63 over 64 cycles with we_valid_o=1, valid_bit_o=0; flush_done_o one pulse at cycle 65; rd asserted meanwhile is ignored.
- **Invalid-first:** way_valid_bits_i=4'b1011, cmp_en_i → way_to_replace_o=2 next cycle.
- **PLRU, 4 ways, set 5 all valid (ICACHE_PLRU_EN):**
  - Rd hits in order ways 0,1,2,3, then cmp_en_i → victim=0.
  - Rd hit way 0, then cmp_en_i → victim=2.
- **Inval vs wr:** inval_i(idx 7, way 3) together with cache_wr_ena_i → addr_valid_o=7, tag_req_valid_o=4'b1000, valid_bit_o=0, data_req_valid_o=0.
- **LFSR build (macro undefined):** 16 refills into a full set → victims follow the LFSR sequence and hit_i has no effect.
